// File: rtl/axi_stream_pkg.sv
// Shared helpers for the AXI-stream width converters: lane-index width
// and conversions between a `mod` field and a byte count.
package axi_stream_pkg;

  typedef int unsigned ratio_t;
  typedef int unsigned uint_t;

  // Width of a lane index for a given narrow/wide ratio (at least 1 bit).
  function automatic uint_t lane_bits(input ratio_t ratio);
    return (ratio <= 2) ? 1 : $clog2(ratio);
  endfunction

  // Width of a `mod` field for a word of word_bytes bytes (at least 1 bit).
  function automatic uint_t mod_bits(input uint_t word_bytes);
    return (word_bytes <= 2) ? 1 : $clog2(word_bytes);
  endfunction

  // Valid byte count of an eop beat: a mod of 0 means every byte is valid.
  function automatic uint_t mod_to_bytes(input uint_t mod, input uint_t word_bytes);
    return (mod == 0) ? word_bytes : mod;
  endfunction

  // Byte count back to a `mod` field: a full word folds to 0.
  function automatic uint_t bytes_to_mod(input uint_t bytes, input uint_t word_bytes);
    return bytes % word_bytes;
  endfunction

endpackage

// File: rtl/axi_stream_width_up_if.sv
// Valid/ready stream bundle with packet framing, byte count, control and
// error fields. The source drives everything except rdy.
interface if_axi_stream #(
  parameter int DAT_BITS = 64,
  parameter int CTL_BITS = 8,
  parameter int MOD_BITS = 3
);
  logic                val;
  logic                rdy;
  logic [DAT_BITS-1:0] dat;
  logic [CTL_BITS-1:0] ctl;
  logic [MOD_BITS-1:0] mod;
  logic                sop;
  logic                eop;
  logic                err;

  modport source (output val, dat, ctl, mod, sop, eop, err, input rdy);
  modport sink   (input val, dat, ctl, mod, sop, eop, err, output rdy);
endinterface

// File: rtl/axi_stream_pack_lane.sv
// Lane write decode for the width up-converter: places one narrow beat
// into its lane of the wide accumulator. Unwritten lanes keep the
// accumulator value, which is zero after every completed word.
module axi_stream_pack_lane #(
  parameter int IN_BITS   = 64,
  parameter int RATIO     = 4,
  parameter int LANE_BITS = 2
) (
  input  logic [LANE_BITS-1:0]     lane,
  input  logic                     wr,
  input  logic [IN_BITS-1:0]       dat,
  input  logic [IN_BITS*RATIO-1:0] acc,
  output logic [IN_BITS*RATIO-1:0] word
);

  logic [RATIO-1:0] lane_we;

  // Decode the target lane and merge the beat into the accumulator image.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latch.
    lane_we = '0;
    word    = acc;
    for (int i = 0; i < RATIO; i++) begin
      lane_we[i] = wr && (lane == LANE_BITS'(i));
      if (lane_we[i]) word[i*IN_BITS +: IN_BITS] = dat;
    end
  end

endmodule

// File: rtl/axi_stream_width_up.sv
// Stream width up-converter: packs RATIO narrow beats into one wide beat,
// lane 0 in the LSBs, preserving sop/eop, byte count, ctl and err.
// Optional macro AXI_WIDTH_UP_PROTO_CHK_EN adds the sticky o_proto_err
// framing checker and forces err on the offending word.
module axi_stream_width_up
  import axi_stream_pkg::*;
#(
  parameter int IN_BITS  = 64,
  parameter int OUT_BITS = 256,
  parameter int CTL_BITS = 8,
  localparam int RATIO        = OUT_BITS / IN_BITS,
  localparam int LANE_BITS    = lane_bits(RATIO),
  localparam int IN_BYTES     = IN_BITS / 8,
  localparam int OUT_BYTES    = OUT_BITS / 8,
  localparam int OUT_MOD_BITS = mod_bits(OUT_BYTES)
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  if_axi_stream.sink           i_axi,
  if_axi_stream.source         o_axi,
  output logic [LANE_BITS-1:0] o_lane
`ifdef AXI_WIDTH_UP_PROTO_CHK_EN
  ,
  output logic                 o_proto_err
`endif
);

  // Accumulator state
  logic [LANE_BITS-1:0]    lane_q;
  logic [OUT_BITS-1:0]     acc_q;
  logic [CTL_BITS-1:0]     ctl_q;
  logic                    sop_q;
  logic                    err_q;

  // Output register
  logic                    out_val_q;
  logic [OUT_BITS-1:0]     out_dat_q;
  logic [CTL_BITS-1:0]     out_ctl_q;
  logic [OUT_MOD_BITS-1:0] out_mod_q;
  logic                    out_sop_q;
  logic                    out_eop_q;
  logic                    out_err_q;

  // Per-beat decisions
  logic                    in_rdy;
  logic                    accept;
  logic                    complete;
  logic                    beat_err;
  logic [OUT_BITS-1:0]     word;
  logic [CTL_BITS-1:0]     word_ctl;
  logic                    word_sop;
  logic                    word_err;
  logic [OUT_MOD_BITS-1:0] word_mod;

  // Ready depends only on the output register, never on the input valid.
  assign in_rdy   = ~i_rst && (~out_val_q || o_axi.rdy);
  assign accept   = i_axi.val && in_rdy;
  assign complete = accept && ((lane_q == LANE_BITS'(RATIO - 1)) || i_axi.eop);

`ifdef AXI_WIDTH_UP_PROTO_CHK_EN
  logic pkt_open_q;
  logic proto_err_q;
  logic proto_viol;

  // A sop must start a fresh packet at lane 0; a non-sop beat needs an open packet.
  assign proto_viol = accept && (i_axi.sop ? ((lane_q != '0) || pkt_open_q) : ~pkt_open_q);
  assign beat_err   = i_axi.err | proto_viol;

  // Track packet framing and hold the violation flag until reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pkt_open_q  <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      if (accept) pkt_open_q <= ~i_axi.eop;
      if (proto_viol) proto_err_q <= 1'b1;
    end
  end

  assign o_proto_err = proto_err_q;
`else
  assign beat_err = i_axi.err;
`endif

  // Lane 0 opens a word: it supplies ctl/sop and restarts the err OR.
  assign word_ctl = (lane_q == '0) ? i_axi.ctl : ctl_q;
  assign word_sop = (lane_q == '0) ? i_axi.sop : sop_q;
  assign word_err = ((lane_q == '0) ? 1'b0 : err_q) | beat_err;

  axi_stream_pack_lane #(
    .IN_BITS  (IN_BITS),
    .RATIO    (RATIO),
    .LANE_BITS(LANE_BITS)
  ) u_pack_lane (
    .lane(lane_q),
    .wr  (accept),
    .dat (i_axi.dat),
    .acc (acc_q),
    .word(word)
  );

  // Wide byte count: full lanes before this beat plus this beat's bytes.
  always_comb begin
    word_mod = '0;
    if (i_axi.eop) begin
      word_mod = OUT_MOD_BITS'(bytes_to_mod(
        uint_t'(lane_q) * uint_t'(IN_BYTES) + mod_to_bytes(uint_t'(i_axi.mod), uint_t'(IN_BYTES)),
        uint_t'(OUT_BYTES)));
    end
  end

  // Advance the fill lane per accepted beat; clear on word completion.
  always_ff @(posedge i_clk) begin
    // NOTE: the wide accumulator is reset because unwritten lanes must read as zero.
    if (i_rst) begin
      lane_q <= '0;
      acc_q  <= '0;
      ctl_q  <= '0;
      sop_q  <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      if (complete) begin
        lane_q <= '0;
        acc_q  <= '0;
        ctl_q  <= '0;
        sop_q  <= 1'b0;
        err_q  <= 1'b0;
      end else begin
        // NOTE: non-blocking so every register samples pre-edge values.
        lane_q <= lane_q + LANE_BITS'(1);
        acc_q  <= word;
        ctl_q  <= word_ctl;
        sop_q  <= word_sop;
        err_q  <= word_err;
      end
    end
  end

  // Output register: load on completion, hold until handshake, reload back-to-back.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      out_val_q <= 1'b0;
      out_dat_q <= '0;
      out_ctl_q <= '0;
      out_mod_q <= '0;
      out_sop_q <= 1'b0;
      out_eop_q <= 1'b0;
      out_err_q <= 1'b0;
    end else if (complete) begin
      out_val_q <= 1'b1;
      out_dat_q <= word;
      out_ctl_q <= word_ctl;
      out_mod_q <= word_mod;
      out_sop_q <= word_sop;
      out_eop_q <= i_axi.eop;
      out_err_q <= word_err;
    end else if (o_axi.rdy) begin
      out_val_q <= 1'b0;
    end
  end

  assign i_axi.rdy = in_rdy;
  assign o_axi.val = out_val_q;
  assign o_axi.dat = out_dat_q;
  assign o_axi.ctl = out_ctl_q;
  assign o_axi.mod = out_mod_q;
  assign o_axi.sop = out_sop_q;
  assign o_axi.eop = out_eop_q;
  assign o_axi.err = out_err_q;
  assign o_lane    = lane_q;

endmodule

// File: tb/tb_axi_stream_width_up.sv
// Directed bench for axi_stream_width_up (64 -> 256 bits, ratio 4).
// Expected wide words are queued by hand before the completing beat and
// matched by a monitor at each output handshake.
module tb_axi_stream_width_up;

  typedef struct {
    logic [255:0] dat;
    logic [7:0]   ctl;
    logic [4:0]   mod;
    logic         sop;
    logic         eop;
    logic         err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] lane;
  int         n_vec = 0;
  int         n_bad = 0;
  int         cyc = 0;
  exp_t       exp_q[$];
  int         hs_cyc[$];
  exp_t       mon_e;
`ifdef AXI_WIDTH_UP_PROTO_CHK_EN
  logic       proto_err;
`endif

  if_axi_stream #(.DAT_BITS(64),  .CTL_BITS(8), .MOD_BITS(3)) in_if ();
  if_axi_stream #(.DAT_BITS(256), .CTL_BITS(8), .MOD_BITS(5)) out_if ();

  axi_stream_width_up #(
    .IN_BITS (64),
    .OUT_BITS(256),
    .CTL_BITS(8)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .i_axi (in_if),
    .o_axi (out_if),
    .o_lane(lane)
`ifdef AXI_WIDTH_UP_PROTO_CHK_EN
    ,
    .o_proto_err(proto_err)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [63:0] dat, input logic [7:0] ctl, input logic [2:0] mod,
                       input logic sop, input logic eop, input logic err);
    in_if.val = 1'b1;
    in_if.dat = dat;
    in_if.ctl = ctl;
    in_if.mod = mod;
    in_if.sop = sop;
    in_if.eop = eop;
    in_if.err = err;
  endtask

  // Present one beat and return #1 after the edge that accepts it.
  task automatic send(input logic [63:0] dat, input logic [7:0] ctl, input logic [2:0] mod,
                      input logic sop, input logic eop, input logic err);
    int waited;
    drive(dat, ctl, mod, sop, eop, err);
    waited = 0;
    @(negedge clk);
    while (!in_if.rdy && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_if.rdy) check("send_timeout", 256'd0, 256'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_if.val = 1'b0;
  endtask

  task automatic expect_word(input logic [255:0] dat, input logic [7:0] ctl, input logic [4:0] mod,
                             input logic sop, input logic eop, input logic err);
    exp_t e;
    e.dat = dat; e.ctl = ctl; e.mod = mod; e.sop = sop; e.eop = eop; e.err = err;
    exp_q.push_back(e);
  endtask

  // Output monitor: compare each handshaked wide beat with the next expected word.
  always @(negedge clk) begin
    if (!rst && out_if.val && out_if.rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 256'd1, 256'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_dat", out_if.dat, mon_e.dat);
        check("out_ctl", {248'd0, out_if.ctl}, {248'd0, mon_e.ctl});
        check("out_mod", {251'd0, out_if.mod}, {251'd0, mon_e.mod});
        check("out_sop", {255'd0, out_if.sop}, {255'd0, mon_e.sop});
        check("out_eop", {255'd0, out_if.eop}, {255'd0, mon_e.eop});
        check("out_err", {255'd0, out_if.err}, {255'd0, mon_e.err});
      end
      hs_cyc.push_back(cyc);
    end
  end

  initial begin
    int waited;
    in_if.val = 1'b0; in_if.dat = '0; in_if.ctl = '0; in_if.mod = '0;
    in_if.sop = 1'b0; in_if.eop = 1'b0; in_if.err = 1'b0;
    out_if.rdy = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_rdy", in_if.rdy, 256'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_val",  out_if.val, 256'd0);
    check("rst_dat",  out_if.dat, 256'd0);
    check("rst_ctl",  out_if.ctl, 256'd0);
    check("rst_mod",  out_if.mod, 256'd0);
    check("rst_sop",  out_if.sop, 256'd0);
    check("rst_eop",  out_if.eop, 256'd0);
    check("rst_err",  out_if.err, 256'd0);
    check("rst_lane", lane, 256'd0);
`ifdef AXI_WIDTH_UP_PROTO_CHK_EN
    check("rst_proto", proto_err, 256'd0);
`endif

    // Four-beat packet, full word, one cycle latency
    expect_word({64'h4444_0000_0000_00A3, 64'h3333_0000_0000_00A2,
                 64'h2222_0000_0000_00A1, 64'h1111_0000_0000_00A0}, 8'h11, 5'd0, 1'b1, 1'b1, 1'b0);
    send(64'h1111_0000_0000_00A0, 8'h11, 3'd0, 1'b1, 1'b0, 1'b0);
    send(64'h2222_0000_0000_00A1, 8'h11, 3'd0, 1'b0, 1'b0, 1'b0);
    send(64'h3333_0000_0000_00A2, 8'h11, 3'd0, 1'b0, 1'b0, 1'b0);
    check("a_lane3", lane, 256'd3);
    check("a_val_before", out_if.val, 256'd0);
    send(64'h4444_0000_0000_00A3, 8'h11, 3'd0, 1'b0, 1'b1, 1'b0);
    idle();
    check("a_val_latency", out_if.val, 256'd1);
    check("a_lane0", lane, 256'd0);

    // Six beats, last mod 3: full word then {0,0,B5,B4} with mod 11
    expect_word({64'hB3, 64'hB2, 64'hB1, 64'hB0}, 8'h22, 5'd0, 1'b1, 1'b0, 1'b0);
    expect_word({64'h0, 64'h0, 64'hB5, 64'hB4}, 8'h22, 5'd11, 1'b0, 1'b1, 1'b0);
    send(64'hB0, 8'h22, 3'd0, 1'b1, 1'b0, 1'b0);
    send(64'hB1, 8'h22, 3'd0, 1'b0, 1'b0, 1'b0);
    send(64'hB2, 8'h22, 3'd0, 1'b0, 1'b0, 1'b0);
    send(64'hB3, 8'h22, 3'd0, 1'b0, 1'b0, 1'b0);
    send(64'hB4, 8'h22, 3'd0, 1'b0, 1'b0, 1'b0);
    send(64'hB5, 8'h22, 3'd3, 1'b0, 1'b1, 1'b0);
    idle();

    // err on beat 1 ORs into the word; ctl comes from beat 0
    expect_word({64'hE3, 64'hE2, 64'hE1, 64'hE0}, 8'h5A, 5'd0, 1'b1, 1'b1, 1'b1);
    send(64'hE0, 8'h5A, 3'd0, 1'b1, 1'b0, 1'b0);
    send(64'hE1, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1);
    send(64'hE2, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0);
    send(64'hE3, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
    idle();
    @(posedge clk); #1;

    // Backpressure: completed word held for 5 cycles, input stalled
    out_if.rdy = 1'b0;
    expect_word({64'hC3, 64'hC2, 64'hC1, 64'hC0}, 8'h33, 5'd0, 1'b1, 1'b1, 1'b0);
    send(64'hC0, 8'h33, 3'd0, 1'b1, 1'b0, 1'b0);
    send(64'hC1, 8'h33, 3'd0, 1'b0, 1'b0, 1'b0);
    send(64'hC2, 8'h33, 3'd0, 1'b0, 1'b0, 1'b0);
    send(64'hC3, 8'h33, 3'd0, 1'b0, 1'b1, 1'b0);
    drive(64'hD0, 8'h44, 3'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_rdy", in_if.rdy, 256'd0);
      check("bp_val", out_if.val, 256'd1);
      check("bp_dat", out_if.dat, {64'hC3, 64'hC2, 64'hC1, 64'hC0});
      check("bp_lane", lane, 256'd0);
    end
    @(posedge clk); #1;
    out_if.rdy = 1'b1;

    // Continuous traffic afterwards: one wide beat every four cycles
    expect_word({64'hD3, 64'hD2, 64'hD1, 64'hD0}, 8'h44, 5'd0, 1'b1, 1'b0, 1'b0);
    expect_word({64'hD7, 64'hD6, 64'hD5, 64'hD4}, 8'h44, 5'd0, 1'b0, 1'b1, 1'b0);
    send(64'hD0, 8'h44, 3'd0, 1'b1, 1'b0, 1'b0);
    send(64'hD1, 8'h44, 3'd0, 1'b0, 1'b0, 1'b0);
    send(64'hD2, 8'h44, 3'd0, 1'b0, 1'b0, 1'b0);
    send(64'hD3, 8'h44, 3'd0, 1'b0, 1'b0, 1'b0);
    send(64'hD4, 8'h44, 3'd0, 1'b0, 1'b0, 1'b0);
    send(64'hD5, 8'h44, 3'd0, 1'b0, 1'b0, 1'b0);
    send(64'hD6, 8'h44, 3'd0, 1'b0, 1'b0, 1'b0);
    send(64'hD7, 8'h44, 3'd0, 1'b0, 1'b1, 1'b0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    if (hs_cyc.size() >= 2) check("thru_gap", hs_cyc[$] - hs_cyc[$-1], 256'd4);
    else check("thru_count", hs_cyc.size(), 256'd2);

    // Reset after two accepted beats discards the partial word
    send(64'hBAD0, 8'h55, 3'd0, 1'b1, 1'b0, 1'b0);
    send(64'hBAD1, 8'h55, 3'd0, 1'b0, 1'b0, 1'b0);
    idle();
    check("mid_lane2", lane, 256'd2);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_in_rdy", in_if.rdy, 256'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_lane", lane, 256'd0);
    check("mid_rst_val", out_if.val, 256'd0);
    expect_word({64'hF3, 64'hF2, 64'hF1, 64'hF0}, 8'h66, 5'd0, 1'b1, 1'b1, 1'b0);
    send(64'hF0, 8'h66, 3'd0, 1'b1, 1'b0, 1'b0);
    send(64'hF1, 8'h66, 3'd0, 1'b0, 1'b0, 1'b0);
    send(64'hF2, 8'h66, 3'd0, 1'b0, 1'b0, 1'b0);
    send(64'hF3, 8'h66, 3'd0, 1'b0, 1'b1, 1'b0);
    idle();

`ifdef AXI_WIDTH_UP_PROTO_CHK_EN
    // Framing checker: sop inside an open word
    check("proto_clean", proto_err, 256'd0);
    expect_word({64'h93, 64'h92, 64'h91, 64'h90}, 8'h77, 5'd0, 1'b1, 1'b1, 1'b1);
    send(64'h90, 8'h77, 3'd0, 1'b1, 1'b0, 1'b0);
    send(64'h91, 8'h77, 3'd0, 1'b0, 1'b0, 1'b0);
    check("proto_before", proto_err, 256'd0);
    send(64'h92, 8'h77, 3'd0, 1'b1, 1'b0, 1'b0);
    check("proto_set", proto_err, 256'd1);
    send(64'h93, 8'h77, 3'd0, 1'b0, 1'b1, 1'b0);
    expect_word({64'h83, 64'h82, 64'h81, 64'h80}, 8'h78, 5'd0, 1'b1, 1'b1, 1'b0);
    send(64'h80, 8'h78, 3'd0, 1'b1, 1'b0, 1'b0);
    send(64'h81, 8'h78, 3'd0, 1'b0, 1'b0, 1'b0);
    send(64'h82, 8'h78, 3'd0, 1'b0, 1'b0, 1'b0);
    send(64'h83, 8'h78, 3'd0, 1'b0, 1'b1, 1'b0);
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("proto_sticky", proto_err, 256'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("proto_cleared", proto_err, 256'd0);
`endif

    // Drain: every expected word must have appeared
    waited = 0;
    while (exp_q.size() != 0 && waited < 20) begin
      @(posedge clk);
      waited++;
    end
    #1;
    check("drain", exp_q.size(), 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
